// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared constants, stage register type and slice helper for pipe_adder
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Reference layout of one pipeline stage at the default geometry
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
    logic [DEF_WIDTH-1:0] rem_a;
    logic [DEF_WIDTH-1:0] rem_b;
  } stage_reg_t;

endpackage

// File: rtl/pipe_adder_slice.sv
// rtl/pipe_adder_slice.sv - add_slice: combinational W-bit ripple-carry adder
module add_slice
  import pipe_adder_pkg::*;
#(
  parameter int W = slice_width(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined valid/ready unsigned adder, one carry slice per stage
// Optional: PIPE_ADDER_SAT_EN clamps sum to all-ones when the final carry is set.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic              load_chain;

  // A stage may load when empty or when its successor loads this cycle
  always_comb begin
    load       = '0;
    load_chain = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i]    = ~vld[i] | load_chain;
      load_chain = load[i];
    end
  end

  assign in_ready = load[0] & ~rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;
    localparam int HI  = LO + SLICE;
    localparam int REM = WIDTH - HI;

    logic             q_valid;
    logic             q_carry;
    logic [HI-1:0]    q_sum;
    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic [SLICE-1:0] slice_sum;
    logic             carry_in;
    logic             carry_out;
    logic             up_valid;
    logic [HI-1:0]    d_sum;
    logic [HI-1:0]    ld_sum;

    if (k == 0) begin : g_head
      assign op_a     = a[SLICE-1:0];
      assign op_b     = b[SLICE-1:0];
      assign carry_in = cin;
      assign up_valid = in_valid;
      assign d_sum    = slice_sum;
    end else begin : g_body
      assign op_a     = g_stage[k-1].g_rem.q_a[SLICE-1:0];
      assign op_b     = g_stage[k-1].g_rem.q_b[SLICE-1:0];
      assign carry_in = g_stage[k-1].q_carry;
      assign up_valid = g_stage[k-1].q_valid;
      assign d_sum    = {slice_sum, g_stage[k-1].q_sum};
    end

    add_slice #(.W(SLICE)) u_slice (
      .a    (op_a),
      .b    (op_b),
      .cin  (carry_in),
      .s    (slice_sum),
      .cout (carry_out)
    );

`ifdef PIPE_ADDER_SAT_EN
    assign ld_sum = ((k == STAGES - 1) && carry_out) ? {HI{1'b1}} : d_sum;
`else
    assign ld_sum = d_sum;
`endif

    // Data only moves with a valid token so a stalled output stays put
    always_ff @(posedge clk) begin
      if (rst) begin
        q_valid <= 1'b0;
        q_carry <= 1'b0;
        q_sum   <= '0;
      end else if (load[k]) begin
        q_valid <= up_valid;
        if (up_valid) begin
          q_carry <= carry_out;
          q_sum   <= ld_sum;
        end
      end
    end

    assign vld[k] = q_valid;

    // Operand bits not yet summed, shifted down so the next slice sits at bit 0
    if (REM > 0) begin : g_rem
      logic [REM-1:0] q_a;
      logic [REM-1:0] q_b;
      logic [REM-1:0] d_a;
      logic [REM-1:0] d_b;

      if (k == 0) begin : g_src_in
        assign d_a = a[WIDTH-1:HI];
        assign d_b = b[WIDTH-1:HI];
      end else begin : g_src_prev
        assign d_a = g_stage[k-1].g_rem.q_a[REM+SLICE-1:SLICE];
        assign d_b = g_stage[k-1].g_rem.q_b[REM+SLICE-1:SLICE];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q_a <= '0;
          q_b <= '0;
        end else if (load[k] && up_valid) begin
          q_a <= d_a;
          q_b <= d_b;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].q_valid & ~rst;
  assign sum       = g_stage[STAGES-1].q_sum;
  assign cout      = g_stage[STAGES-1].q_carry;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - directed self-checking bench for pipe_adder (WIDTH=16, STAGES=4)
module tb_pipe_adder;

`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_q [$];

  logic [15:0] tv_a  [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h0000, 16'hABCD, 16'h00F0, 16'hC000};
  logic [15:0] tv_b  [8] = '{16'h1111, 16'hFFFF, 16'h8000, 16'hF0F0, 16'h0000, 16'h1234, 16'h0010, 16'h4001};
  logic        tv_c  [8] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
  logic [15:0] tv_s  [8] = '{16'h2345, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 16'hBE01, 16'h0100, 16'h0001};
  logic        tv_co [8] = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0,     1'b1};

  pipe_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] tv_exp(input int i);
    return {tv_co[i], (SAT && tv_co[i]) ? 16'hFFFF : tv_s[i]};
  endfunction

  task automatic single(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [15:0] es, input logic ec);
    int lat;
    @(negedge clk);
    a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
  endtask

  task automatic stream(input string tag, input int stall_at, input int stall_len);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int first = -1;
    int last = -1;
    logic [16:0] e;
    bit stalled;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalled;
      in_valid  = (idx < 8);
      if (idx < 8) begin
        a = tv_a[idx]; b = tv_b[idx]; cin = tv_c[idx];
      end
      #1;
      if (stalled && out_valid && exp_q.size() > 0)
        check({tag, "_stall_sum"}, sum, exp_q[0][15:0]);
      if (stalled && cyc == stall_at + stall_len - 1)
        check({tag, "_stall_in_ready"}, in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_out"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, "_sum"}, sum, e[15:0]);
          check({tag, "_cout"}, cout, e[16]);
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(tv_exp(idx));
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_count"}, got, 8);
    if (stall_len == 0)
      check({tag, "_back_to_back"}, last - first, 7);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);
    check("post_rst_cout", cout, 0);
    check("post_rst_in_ready", in_ready, 1);

    single("carry8", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    single("wrap", 16'hFFFF, 16'h0001, 1'b0, SAT ? 16'hFFFF : 16'h0000, 1'b1);
    single("ripple", 16'h7FFF, 16'h8000, 1'b1, SAT ? 16'hFFFF : 16'h0000, 1'b1);

    stream("b2b", 1000, 0);
    stream("stall", 6, 6);

    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = tv_a[i]; b = tv_b[i]; cin = tv_c[i];
      #1;
      check("flush_in_ready", in_ready, 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("flush_rst_in_ready", in_ready, 0);
    check("flush_rst_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    check("flush_sum", sum, 0);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flush_no_stale", seen, 0);
    single("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
